// File: rtl/seg_char_render.sv
// Seven-segment glyph renderer: frame-latched position/code, two-stage pixel pipeline.
// Optional frame-counting blink gate is built when SEG_CHAR_BLINK_EN is defined.
module seg_char_render #(
  parameter int W            = 26,
  parameter int H            = 40,
  parameter int T            = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [9:0] start_x,
  input  logic [9:0] start_y,
  input  logic [3:0] code,
  input  logic       blink_en,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       pix_valid,
  output logic       display,
  output logic       display_valid
);

  localparam int M = (H - T) / 2;

  localparam logic [10:0] P_T    = 11'(T);
  localparam logic [10:0] P_W    = 11'(W);
  localparam logic [10:0] P_H    = 11'(H);
  localparam logic [10:0] P_WMT  = 11'(W - T);
  localparam logic [10:0] P_HMT  = 11'(H - T);
  localparam logic [10:0] P_M    = 11'(M);
  localparam logic [10:0] P_MPT  = 11'(M + T);

  // Handshake: no backpressure; every cycle carries one pixel, pix_valid marks
  // visible ones and is delayed two cycles to become display_valid.

  logic [9:0] sx_q, sy_q;
  logic [3:0] scode_q;

  logic [9:0]  eff_x, eff_y;
  logic [3:0]  eff_code;
  logic [10:0] dx_d, dy_d;
  logic        inside_d;
  logic [6:0]  mask_d;
  logic        vis_d;

  logic [10:0] dx_q, dy_q;
  logic        inside_q;
  logic [6:0]  mask_q;
  logic        valid_q;
  logic        vis_q;

  logic        display_q, display_valid_q;

  // The frame_start pixel sees the incoming values, not the stale shadows.
  always_comb begin
    eff_x    = frame_start ? start_x : sx_q;
    eff_y    = frame_start ? start_y : sy_q;
    eff_code = frame_start ? code    : scode_q;
    dx_d     = {1'b0, x} - {1'b0, eff_x};
    dy_d     = {1'b0, y} - {1'b0, eff_y};
    inside_d = !dx_d[10] && (dx_d < P_W) && !dy_d[10] && (dy_d < P_H);
  end

  always_comb begin
    mask_d = 7'h00;
    case (eff_code)
      4'd0:    mask_d = 7'h3F;
      4'd1:    mask_d = 7'h06;
      4'd2:    mask_d = 7'h5B;
      4'd3:    mask_d = 7'h4F;
      4'd4:    mask_d = 7'h66;
      4'd5:    mask_d = 7'h6D;
      4'd6:    mask_d = 7'h7D;
      4'd7:    mask_d = 7'h07;
      4'd8:    mask_d = 7'h7F;
      4'd9:    mask_d = 7'h6F;
      4'd11:   mask_d = 7'h40;
      4'd12:   mask_d = 7'h73;
      default: mask_d = 7'h00;
    endcase
  end

`ifdef SEG_CHAR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt_q;
  logic          phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (frame_start) begin
      if (bcnt_q == BLAST) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  // Phase change at an edge takes effect from the next pixel onwards.
  assign vis_d = phase_q | ~blink_en;
`else
  logic unused_blink;
  assign unused_blink = blink_en;
  assign vis_d        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q    <= '0;
      sy_q    <= '0;
      scode_q <= 4'd10;
    end else if (frame_start) begin
      sx_q    <= start_x;
      sy_q    <= start_y;
      scode_q <= code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q     <= '0;
      dy_q     <= '0;
      inside_q <= 1'b0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
      vis_q    <= 1'b0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      inside_q <= inside_d;
      mask_q   <= mask_d;
      valid_q  <= pix_valid;
      vis_q    <= vis_d;
    end
  end

  // Segment hit test; dx/dy are known non-negative and in-box when inside_q.
  logic col_l, col_m, col_r;
  logic row_a, row_top, row_g, row_bot, row_d;
  logic [6:0] seg_hit;
  logic       display_d;

  always_comb begin
    col_l   = dx_q < P_T;
    col_m   = (dx_q >= P_T) && (dx_q < P_WMT);
    col_r   = dx_q >= P_WMT;
    row_a   = dy_q < P_T;
    row_top = (dy_q >= P_T) && (dy_q < P_M);
    row_g   = (dy_q >= P_M) && (dy_q < P_MPT);
    row_bot = (dy_q >= P_MPT) && (dy_q < P_HMT);
    row_d   = dy_q >= P_HMT;
    seg_hit[0] = col_m & row_a;
    seg_hit[1] = col_r & row_top;
    seg_hit[2] = col_r & row_bot;
    seg_hit[3] = col_m & row_d;
    seg_hit[4] = col_l & row_bot;
    seg_hit[5] = col_l & row_top;
    seg_hit[6] = col_m & row_g;
    display_d  = inside_q & valid_q & vis_q & (|(seg_hit & mask_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      display_q       <= 1'b0;
      display_valid_q <= 1'b0;
    end else begin
      display_q       <= display_d;
      display_valid_q <= valid_q;
    end
  end

  assign display       = display_q;
  assign display_valid = display_valid_q;

endmodule
